// File: rtl/riscv_pkg.sv
// Shared RV32I types: ALU ops, opcodes, decode bundle and the ID/EX register.
package riscv_pkg;

    localparam int unsigned XLEN_P = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'h37,
        OPC_AUIPC  = 7'h17,
        OPC_JAL    = 7'h6f,
        OPC_JALR   = 7'h67,
        OPC_BRANCH = 7'h63,
        OPC_LOAD   = 7'h03,
        OPC_STORE  = 7'h23,
        OPC_OP_IMM = 7'h13,
        OPC_OP     = 7'h33
    } opcode_e;

    typedef struct packed {
        logic [XLEN_P-1:0] imm;
        alu_op_e           alu_op;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              reg_wr;
        logic              mem_to_reg;
        logic              branch;
        logic              jump;
        logic              illegal;
        logic              use_rs1;
        logic              use_rs2;
    } dec_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN_P-1:0] pc;
        logic [XLEN_P-1:0] rs1_val;
        logic [XLEN_P-1:0] rs2_val;
        logic [XLEN_P-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        alu_op_e           alu_op;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              reg_wr;
        logic              mem_to_reg;
        logic              branch;
        logic              jump;
        logic              illegal;
    } id_ex_t;

    function automatic alu_op_e f3_alu(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        unique case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_stage_decoder.sv
// Combinational RV32I decoder: instruction word to control, immediate, illegal.
module decoder
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        dec_o        = '0;
        dec_o.alu_op = ALU_ADD;
        legal        = 1'b1;
        case (opc)
            OPC_LUI: begin
                dec_o.imm     = imm_u;
                dec_o.alu_op  = ALU_PASSB;
                dec_o.alu_src = 1'b1;
                dec_o.reg_wr  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.imm     = imm_u;
                dec_o.alu_src = 1'b1;
                dec_o.reg_wr  = 1'b1;
            end
            OPC_JAL: begin
                dec_o.imm     = imm_j;
                dec_o.alu_src = 1'b1;
                dec_o.reg_wr  = 1'b1;
                dec_o.jump    = 1'b1;
            end
            OPC_JALR: begin
                dec_o.imm     = imm_i;
                dec_o.alu_src = 1'b1;
                dec_o.reg_wr  = 1'b1;
                dec_o.jump    = 1'b1;
                dec_o.use_rs1 = 1'b1;
                legal         = (f3 == 3'd0);
            end
            OPC_BRANCH: begin
                dec_o.imm     = imm_b;
                dec_o.alu_op  = ALU_SUB;
                dec_o.branch  = 1'b1;
                dec_o.use_rs1 = 1'b1;
                dec_o.use_rs2 = 1'b1;
                legal         = (f3[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                dec_o.imm        = imm_i;
                dec_o.alu_src    = 1'b1;
                dec_o.mem_read   = 1'b1;
                dec_o.mem_to_reg = 1'b1;
                dec_o.reg_wr     = 1'b1;
                dec_o.use_rs1    = 1'b1;
                legal            = (f3 != 3'd3) && (f3 < 3'd6);
            end
            OPC_STORE: begin
                dec_o.imm       = imm_s;
                dec_o.alu_src   = 1'b1;
                dec_o.mem_write = 1'b1;
                dec_o.use_rs1   = 1'b1;
                dec_o.use_rs2   = 1'b1;
                legal           = (f3 < 3'd3);
            end
            OPC_OP_IMM: begin
                dec_o.imm     = imm_i;
                dec_o.alu_src = 1'b1;
                dec_o.reg_wr  = 1'b1;
                dec_o.use_rs1 = 1'b1;
                // Only the shift-right form reads bit 30 as an op modifier.
                dec_o.alu_op  = f3_alu(f3, (f3 == 3'd5) && f7[5]);
                if (f3 == 3'd1) begin
                    legal = (f7 == 7'h00);
                end else if (f3 == 3'd5) begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                end
            end
            OPC_OP: begin
                dec_o.reg_wr  = 1'b1;
                dec_o.use_rs1 = 1'b1;
                dec_o.use_rs2 = 1'b1;
                dec_o.alu_op  = f3_alu(f3, f7[5]);
                legal = (f7 == 7'h00) ||
                        ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_o.imm        = '0;
            dec_o.alu_op     = ALU_ADD;
            dec_o.alu_src    = 1'b0;
            dec_o.mem_read   = 1'b0;
            dec_o.mem_write  = 1'b0;
            dec_o.reg_wr     = 1'b0;
            dec_o.mem_to_reg = 1'b0;
            dec_o.branch     = 1'b0;
            dec_o.jump       = 1'b0;
            dec_o.illegal    = 1'b1;
        end
        if (instr_i[11:7] == 5'd0) begin
            dec_o.reg_wr = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: WB bypass, load-use bubbles, stall/flush and the ID/EX register.
module id_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    localparam int unsigned RegAw = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_ready,
    output logic [RegAw-1:0] ra,
    output logic [RegAw-1:0] rb,
    input  logic [XLEN-1:0]  rda,
    input  logic [XLEN-1:0]  rdb,
    input  logic [RegAw-1:0] wb_wa,
    input  logic [XLEN-1:0]  wb_wda,
    input  logic             wb_reg_wr,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_val,
    output logic [XLEN-1:0]  ex_rs2_val,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_wr,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic             ex_illegal
);

    dec_t            dec;
    id_ex_t          id_ex_d, id_ex_q;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            load_use;

    decoder u_decoder (
        .instr_i (if_instr),
        .dec_o   (dec)
    );

    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];
    assign ra  = rs1[RegAw-1:0];
    assign rb  = rs2[RegAw-1:0];

    // The register file does not forward its own same-cycle write.
    assign rs1_val = (wb_reg_wr && wb_wa != '0 && wb_wa == ra) ? wb_wda : rda;
    assign rs2_val = (wb_reg_wr && wb_wa != '0 && wb_wa == rb) ? wb_wda : rdb;

    assign load_use = if_valid && id_ex_q.valid && id_ex_q.mem_read &&
                      id_ex_q.rd != 5'd0 &&
                      ((dec.use_rs1 && rs1 == id_ex_q.rd) ||
                       (dec.use_rs2 && rs2 == id_ex_q.rd));

    assign id_ready = !reset && (flush || (!ex_stall && !load_use));

    always_comb begin
        id_ex_d = id_ex_q;
        if (flush) begin
            id_ex_d.valid = 1'b0;
        end else if (ex_stall) begin
            id_ex_d = id_ex_q;
        end else if (load_use) begin
            // Clearing mem_read retires the hazard so the consumer issues next edge.
            id_ex_d.valid    = 1'b0;
            id_ex_d.mem_read = 1'b0;
        end else begin
            id_ex_d.valid      = if_valid;
            id_ex_d.pc         = if_pc;
            id_ex_d.rs1_val    = rs1_val;
            id_ex_d.rs2_val    = rs2_val;
            id_ex_d.imm        = dec.imm;
            id_ex_d.rs1        = rs1;
            id_ex_d.rs2        = rs2;
            id_ex_d.rd         = if_instr[11:7];
            id_ex_d.alu_op     = dec.alu_op;
            id_ex_d.alu_src    = dec.alu_src;
            id_ex_d.mem_read   = dec.mem_read;
            id_ex_d.mem_write  = dec.mem_write;
            id_ex_d.reg_wr     = dec.reg_wr;
            id_ex_d.mem_to_reg = dec.mem_to_reg;
            id_ex_d.branch     = dec.branch;
            id_ex_d.jump       = dec.jump;
            id_ex_d.illegal    = dec.illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ex_valid      = id_ex_q.valid;
    assign ex_pc         = id_ex_q.pc;
    assign ex_rs1_val    = id_ex_q.rs1_val;
    assign ex_rs2_val    = id_ex_q.rs2_val;
    assign ex_imm        = id_ex_q.imm;
    assign ex_rs1        = id_ex_q.rs1;
    assign ex_rs2        = id_ex_q.rs2;
    assign ex_rd         = id_ex_q.rd;
    assign ex_alu_op     = id_ex_q.alu_op;
    assign ex_alu_src    = id_ex_q.alu_src;
    assign ex_mem_read   = id_ex_q.mem_read;
    assign ex_mem_write  = id_ex_q.mem_write;
    assign ex_reg_wr     = id_ex_q.reg_wr;
    assign ex_mem_to_reg = id_ex_q.mem_to_reg;
    assign ex_branch     = id_ex_q.branch;
    assign ex_jump       = id_ex_q.jump;
    assign ex_illegal    = id_ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage against a behavioural decode/pipeline model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset, if_valid, wb_reg_wr, ex_stall, flush;
    logic [31:0] if_instr, if_pc, rda, rdb, wb_wda;
    logic [4:0]  wb_wa, ra, rb;
    logic        id_ready, ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_wr;
    logic        ex_mem_to_reg, ex_branch, ex_jump, ex_illegal;

    id_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .id_ready(id_ready), .ra(ra), .rb(rb), .rda(rda),
        .rdb(rdb), .wb_wa(wb_wa), .wb_wda(wb_wda), .wb_reg_wr(wb_reg_wr),
        .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_wr(ex_reg_wr), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        int          alu;
        logic src, mr, mw, rw, m2r, br, jp, ill, u1, u2;
    } ctl_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  rs1, rs2, rd;
        int          alu;
        logic src, mr, mw, rw, m2r, br, jp, ill;
    } ex_m_t;

    localparam int OPS[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    localparam logic [6:0] OPCS[9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                                       7'h03, 7'h23, 7'h13, 7'h33};

    logic [31:0] rf [32];
    ex_m_t exp_m, exp_nx;
    logic  exp_rdy, rdy_seen, chk_en;
    int    n_chk, n_pass;

    always_comb begin
        rda = rf[if_instr[19:15]];
        rdb = rf[if_instr[24:20]];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    endtask

    function automatic ctl_t ref_dec(input logic [31:0] w);
        ctl_t c;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic ok;
        int ii, is, ib, ij;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        ii = $signed(w[31:20]);
        is = $signed({w[31:25], w[11:7]});
        ib = $signed({w[31], w[7], w[30:25], w[11:8]}) * 2;
        ij = $signed({w[31], w[19:12], w[20], w[30:21]}) * 2;
        c = '{default: 0};
        ok = 1'b1;
        case (op)
            7'h37: begin c.imm = w & 32'hffff_f000; c.alu = 10; c.src = 1; c.rw = 1; end
            7'h17: begin c.imm = w & 32'hffff_f000; c.src = 1; c.rw = 1; end
            7'h6f: begin c.imm = 32'(ij); c.src = 1; c.rw = 1; c.jp = 1; end
            7'h67: begin
                c.imm = 32'(ii); c.src = 1; c.rw = 1; c.jp = 1; c.u1 = 1;
                ok = (f3 == 0);
            end
            7'h63: begin
                c.imm = 32'(ib); c.alu = 1; c.br = 1; c.u1 = 1; c.u2 = 1;
                ok = !(f3 == 2 || f3 == 3);
            end
            7'h03: begin
                c.imm = 32'(ii); c.src = 1; c.mr = 1; c.m2r = 1; c.rw = 1; c.u1 = 1;
                ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'h23: begin
                c.imm = 32'(is); c.src = 1; c.mw = 1; c.u1 = 1; c.u2 = 1;
                ok = (f3 <= 2);
            end
            7'h13: begin
                c.imm = 32'(ii); c.src = 1; c.rw = 1; c.u1 = 1; c.alu = OPS[f3];
                if (f3 == 5 && f7 == 7'h20) c.alu = 7;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
            end
            7'h33: begin
                c.rw = 1; c.u1 = 1; c.u2 = 1; c.alu = OPS[f3];
                if (f7 == 7'h20) begin
                    ok = (f3 == 0 || f3 == 5);
                    c.alu = (f3 == 0) ? 1 : 7;
                end else begin
                    ok = (f7 == 0);
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            c.imm = 0; c.alu = 0; c.src = 0; c.mr = 0; c.mw = 0; c.rw = 0;
            c.m2r = 0; c.br = 0; c.jp = 0; c.ill = 1;
        end
        if (w[11:7] == 0) c.rw = 0;
        return c;
    endfunction

    function automatic ex_m_t zero_m();
        ex_m_t m;
        m = '{default: 0};
        return m;
    endfunction

    task automatic step(input logic rst, input logic iv, input logic [31:0] ins,
                        input logic [31:0] pc, input logic wr, input logic [4:0] wa,
                        input logic [31:0] wd, input logic st, input logic fl);
        ctl_t c;
        logic [4:0] s1, s2;
        logic [31:0] v1, v2;
        logic lu;
        @(negedge clk);
        reset = rst; if_valid = iv; if_instr = ins; if_pc = pc;
        wb_reg_wr = wr; wb_wa = wa; wb_wda = wd; ex_stall = st; flush = fl;
        #1;
        c = ref_dec(ins);
        s1 = ins[19:15];
        s2 = ins[24:20];
        v1 = (wr && wa != 0 && wa == s1) ? wd : rf[s1];
        v2 = (wr && wa != 0 && wa == s2) ? wd : rf[s2];
        lu = iv && exp_m.valid && exp_m.mr && exp_m.rd != 0 &&
             ((c.u1 && s1 == exp_m.rd) || (c.u2 && s2 == exp_m.rd));
        exp_rdy = !rst && (fl || (!st && !lu));
        chk("id_ready", id_ready, exp_rdy);
        chk("ra", ra, s1);
        chk("rb", rb, s2);
        rdy_seen = id_ready;
        exp_nx = exp_m;
        if (rst) exp_nx = zero_m();
        else if (fl) exp_nx.valid = 0;
        else if (st) exp_nx = exp_m;
        else if (lu) begin
            exp_nx.valid = 0;
            exp_nx.mr = 0;
        end else begin
            exp_nx = '{valid: iv, pc: pc, r1: v1, r2: v2, imm: c.imm,
                       rs1: s1, rs2: s2, rd: ins[11:7], alu: c.alu,
                       src: c.src, mr: c.mr, mw: c.mw, rw: c.rw,
                       m2r: c.m2r, br: c.br, jp: c.jp, ill: c.ill};
        end
        chk_en = 1'b1;
        @(posedge clk);
        exp_m = exp_nx;
        if (wr && wa != 0) rf[wa] <= wd;
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("ex_valid", ex_valid, exp_m.valid);
            chk("ex_pc", ex_pc, exp_m.pc);
            chk("ex_rs1_val", ex_rs1_val, exp_m.r1);
            chk("ex_rs2_val", ex_rs2_val, exp_m.r2);
            chk("ex_imm", ex_imm, exp_m.imm);
            chk("ex_rs1", ex_rs1, exp_m.rs1);
            chk("ex_rs2", ex_rs2, exp_m.rs2);
            chk("ex_rd", ex_rd, exp_m.rd);
            chk("ex_alu_op", ex_alu_op, 32'(exp_m.alu));
            chk("ex_alu_src", ex_alu_src, exp_m.src);
            chk("ex_mem_read", ex_mem_read, exp_m.mr);
            chk("ex_mem_write", ex_mem_write, exp_m.mw);
            chk("ex_reg_wr", ex_reg_wr, exp_m.rw);
            chk("ex_mem_to_reg", ex_mem_to_reg, exp_m.m2r);
            chk("ex_branch", ex_branch, exp_m.br);
            chk("ex_jump", ex_jump, exp_m.jp);
            chk("ex_illegal", ex_illegal, exp_m.ill);
        end
    end

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] s1,
                                          input logic [11:0] imm);
        return {imm, s1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, s2, s1, f3, rd, op};
    endfunction

    logic [31:0] addi_i, add_i, lw_i, ci, cpc;
    logic        cv, lfl, r_rst, r_wr, r_st, r_fl;
    logic [4:0]  r_wa;
    logic [31:0] r_wd;

    initial begin
        n_chk = 0; n_pass = 0; chk_en = 1'b0; exp_rdy = 1'b0;
        reset = 1'b1; if_valid = 0; if_instr = 0; if_pc = 0;
        wb_reg_wr = 0; wb_wa = 0; wb_wda = 0; ex_stall = 0; flush = 0;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_reset_valid", ex_valid, 0);
        chk("lit_reset_pc", ex_pc, 0);
        chk("lit_reset_ready", rdy_seen, 0);

        step(0, 0, 0, 0, 1, 5, 32'h10, 0, 0);
        addi_i = enc_i(7'h13, 6, 0, 5, 12'd3);
        step(0, 1, addi_i, 32'h100, 0, 0, 0, 0, 0);
        chk("lit_addi_valid", ex_valid, 1);
        chk("lit_addi_rs1", ex_rs1_val, 32'h10);
        chk("lit_addi_imm", ex_imm, 3);
        chk("lit_addi_src", ex_alu_src, 1);
        chk("lit_addi_rd", ex_rd, 6);
        chk("lit_addi_rw", ex_reg_wr, 1);

        step(0, 1, enc_r(0, 0, 7, 0, 8, 7'h33), 32'h104, 1, 7, 32'hdead, 0, 0);
        chk("lit_byp_rs1", ex_rs1_val, 32'hdead);
        chk("lit_byp_rs2", ex_rs2_val, 0);

        lw_i  = enc_i(7'h03, 9, 3'd2, 1, 12'd0);
        add_i = enc_r(0, 2, 9, 0, 10, 7'h33);
        step(0, 1, lw_i, 32'h108, 0, 0, 0, 0, 0);
        chk("lit_lw_mr", ex_mem_read, 1);
        step(0, 1, add_i, 32'h10c, 0, 0, 0, 0, 0);
        chk("lit_lu_ready", rdy_seen, 0);
        chk("lit_lu_valid", ex_valid, 0);
        chk("lit_lu_mr", ex_mem_read, 0);
        step(0, 1, add_i, 32'h10c, 1, 9, 32'h1234, 0, 0);
        chk("lit_lu2_ready", rdy_seen, 1);
        chk("lit_lu2_valid", ex_valid, 1);
        chk("lit_lu2_rs1", ex_rs1_val, 32'h1234);
        chk("lit_lu2_rd", ex_rd, 10);

        step(0, 1, lw_i, 32'h110, 0, 0, 0, 0, 0);
        step(0, 1, add_i, 32'h114, 0, 0, 0, 1, 1);
        chk("lit_flush_ready", rdy_seen, 1);
        chk("lit_flush_valid", ex_valid, 0);

        step(0, 1, addi_i, 32'h118, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, enc_r(0, 5, 5, 0, 11, 7'h33), 32'h11c, 0, 0, 0, 1, 0);
            chk("lit_stall_ready", rdy_seen, 0);
            chk("lit_stall_rd", ex_rd, 6);
            chk("lit_stall_pc", ex_pc, 32'h118);
        end
        step(0, 1, enc_r(0, 5, 5, 0, 11, 7'h33), 32'h11c, 0, 0, 0, 0, 0);
        chk("lit_unstall_rd", ex_rd, 11);
        chk("lit_unstall_pc", ex_pc, 32'h11c);
        chk("lit_unstall_rs1", ex_rs1_val, 32'h10);

        step(1, 1, addi_i, 32'h120, 0, 0, 0, 0, 0);
        chk("lit_midrst_ready", rdy_seen, 0);
        chk("lit_midrst_valid", ex_valid, 0);
        chk("lit_midrst_imm", ex_imm, 0);
        chk("lit_midrst_rd", ex_rd, 0);

        step(0, 1, 32'h0000_01ff, 32'h124, 0, 0, 0, 0, 0);
        chk("lit_ill_flag", ex_illegal, 1);
        chk("lit_ill_rw", ex_reg_wr, 0);
        chk("lit_ill_valid", ex_valid, 1);

        cv = 0; ci = 0; cpc = 32'h200; lfl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (exp_rdy || lfl) begin
                cv  = ($urandom_range(0, 3) != 0);
                ci  = $urandom;
                if ($urandom_range(0, 9) != 0) ci[6:0] = OPCS[$urandom_range(0, 8)];
                if ($urandom_range(0, 9) < 7)
                    ci[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
                ci[11:7]  = 5'($urandom_range(0, 7));
                ci[19:15] = 5'($urandom_range(0, 7));
                ci[24:20] = 5'($urandom_range(0, 7));
                cpc = cpc + 4;
            end
            r_rst = ($urandom_range(0, 39) == 0);
            r_st  = ($urandom_range(0, 4) == 0);
            r_fl  = ($urandom_range(0, 9) == 0);
            r_wr  = ($urandom_range(0, 1) != 0);
            r_wa  = 5'($urandom_range(0, 7));
            r_wd  = $urandom;
            step(r_rst, cv, ci, cpc, r_wr, r_wa, r_wd, r_st, r_fl);
            lfl = r_fl;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
